// File: rtl/traffic_conflict_monitor.sv
// Independent safety monitor for traffic_control_system outputs: detects conflicting greens,
// illegal phase-count stepping and all-dark stalls, then latches a coded fault until cleared.
module traffic_conflict_monitor #(
  parameter int unsigned ARM_CYCLES = 4,   // 1..255
  parameter int unsigned PERSIST    = 2,   // 1..15
  parameter int unsigned DARK_LIMIT = 32   // 1..255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] count,
  input  logic       North_Ped,
  input  logic       North_Left,
  input  logic       North_Fwd,
  input  logic       North_Right,
  input  logic       East_Ped,
  input  logic       East_Left,
  input  logic       East_Fwd,
  input  logic       East_Right,
  input  logic       South_Ped,
  input  logic       South_Left,
  input  logic       South_Fwd,
  input  logic       South_Right,
  input  logic       West_Ped,
  input  logic       West_Left,
  input  logic       West_Fwd,
  input  logic       West_Right,
  input  logic       clr_fault,
  output logic       armed,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic       flash_req
);

  typedef enum logic [1:0] {
    S_ARMING  = 2'd0,
    S_MONITOR = 2'd1,
    S_FAULT   = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    CODE_NONE = 3'd0,
    CODE_AXIS = 3'd1,
    CODE_PED  = 3'd2,
    CODE_STEP = 3'd3,
    CODE_DARK = 3'd4
  } fault_code_e;

  localparam logic [7:0] ARM_LAST     = 8'(ARM_CYCLES - 1);
  localparam logic [3:0] PERSIST_MAX  = 4'(PERSIST);
  localparam logic [3:0] PERSIST_LAST = 4'(PERSIST - 1);
  localparam logic [7:0] DARK_MAX     = 8'(DARK_LIMIT);
  localparam logic [7:0] DARK_LAST    = 8'(DARK_LIMIT - 1);

  state_e      r_state;
  logic [7:0]  r_arm_cnt;
  logic [3:0]  r_ax_cnt;
  logic [3:0]  r_pd_cnt;
  logic [7:0]  r_dk_cnt;
  logic [3:0]  r_prev_count;

  logic        w_ns_veh;
  logic        w_ew_veh;
  logic        w_ax;
  logic        w_pd;
  logic        w_st;
  logic        w_dk;
  logic        w_ax_hit;
  logic        w_pd_hit;
  logic        w_dk_hit;
  logic        w_trigger;
  logic [3:0]  w_ax_next;
  logic [3:0]  w_pd_next;
  logic [7:0]  w_dk_next;
  fault_code_e w_code;

  // Raw conditions on the current inputs.
  assign w_ns_veh = North_Left | North_Fwd | North_Right |
                    South_Left | South_Fwd | South_Right;
  assign w_ew_veh = East_Left  | East_Fwd  | East_Right  |
                    West_Left  | West_Fwd  | West_Right;
  assign w_ax     = w_ns_veh & w_ew_veh;

  // A pedestrian crossing conflicts with its own approach and with the opposing left turn.
  assign w_pd = (North_Ped & (North_Left | North_Fwd | North_Right | South_Left)) |
                (South_Ped & (South_Left | South_Fwd | South_Right | North_Left)) |
                (East_Ped  & (East_Left  | East_Fwd  | East_Right  | West_Left))  |
                (West_Ped  & (West_Left  | West_Fwd  | West_Right  | East_Left));

  assign w_st = (count != 4'(r_prev_count + 4'd1));

  assign w_dk = ~(North_Ped | North_Left | North_Fwd | North_Right |
                  East_Ped  | East_Left  | East_Fwd  | East_Right  |
                  South_Ped | South_Left | South_Fwd | South_Right |
                  West_Ped  | West_Left  | West_Fwd  | West_Right);

  // Saturating debounce counters; any false cycle restarts them.
  assign w_ax_next = !w_ax ? 4'd0 : (r_ax_cnt >= PERSIST_MAX) ? PERSIST_MAX : r_ax_cnt + 4'd1;
  assign w_pd_next = !w_pd ? 4'd0 : (r_pd_cnt >= PERSIST_MAX) ? PERSIST_MAX : r_pd_cnt + 4'd1;
  assign w_dk_next = !w_dk ? 8'd0 : (r_dk_cnt >= DARK_MAX)    ? DARK_MAX    : r_dk_cnt + 8'd1;

  assign w_ax_hit  = w_ax & (r_ax_cnt >= PERSIST_LAST);
  assign w_pd_hit  = w_pd & (r_pd_cnt >= PERSIST_LAST);
  assign w_dk_hit  = w_dk & (r_dk_cnt >= DARK_LAST);
  assign w_trigger = w_ax_hit | w_pd_hit | w_st | w_dk_hit;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_code = CODE_NONE;
    if (w_ax_hit)      w_code = CODE_AXIS;
    else if (w_pd_hit) w_code = CODE_PED;
    else if (w_st)     w_code = CODE_STEP;
    else if (w_dk_hit) w_code = CODE_DARK;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_ARMING;
      r_arm_cnt    <= 8'd0;
      r_ax_cnt     <= 4'd0;
      r_pd_cnt     <= 4'd0;
      r_dk_cnt     <= 8'd0;
      r_prev_count <= 4'd0;
      armed        <= 1'b0;
      fault        <= 1'b0;
      fault_code   <= CODE_NONE;
      flash_req    <= 1'b0;
    end else begin
      r_prev_count <= count;
      case (r_state)
        S_ARMING: begin
          r_ax_cnt <= 4'd0;
          r_pd_cnt <= 4'd0;
          r_dk_cnt <= 8'd0;
          if (r_arm_cnt >= ARM_LAST) begin
            r_state   <= S_MONITOR;
            r_arm_cnt <= 8'd0;
            armed     <= 1'b1;
          end else begin
            r_arm_cnt <= r_arm_cnt + 8'd1;
          end
        end

        S_MONITOR: begin
          if (w_trigger) begin
            r_state    <= S_FAULT;
            r_ax_cnt   <= 4'd0;
            r_pd_cnt   <= 4'd0;
            r_dk_cnt   <= 8'd0;
            armed      <= 1'b0;
            fault      <= 1'b1;
            flash_req  <= 1'b1;
            fault_code <= w_code;
          end else begin
            r_ax_cnt <= w_ax_next;
            r_pd_cnt <= w_pd_next;
            r_dk_cnt <= w_dk_next;
          end
        end

        S_FAULT: begin
          r_ax_cnt <= 4'd0;
          r_pd_cnt <= 4'd0;
          r_dk_cnt <= 8'd0;
          // Clearing is refused while a conflict is still being driven.
          if (clr_fault && !w_ax && !w_pd) begin
            r_state    <= S_ARMING;
            r_arm_cnt  <= 8'd0;
            fault      <= 1'b0;
            flash_req  <= 1'b0;
            fault_code <= CODE_NONE;
          end
        end

        default: begin
          r_state    <= S_ARMING;
          r_arm_cnt  <= 8'd0;
          r_ax_cnt   <= 4'd0;
          r_pd_cnt   <= 4'd0;
          r_dk_cnt   <= 8'd0;
          armed      <= 1'b0;
          fault      <= 1'b0;
          flash_req  <= 1'b0;
          fault_code <= CODE_NONE;
        end
      endcase
    end
  end

endmodule
